// File: rtl/md5_ctrl_pkg.sv
// md5_ctrl_pkg
//   Shared constants and the controller state type for the MD5 message
//   scheduler/padder. Imported by the bus interface, the block buffer and
//   the scheduler top.
package md5_ctrl_pkg;

  localparam int MD5_BLOCK_BITS  = 512;
  localparam int MD5_BLOCK_BYTES = 64;

  // First byte written after the message payload.
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;
  // Highest byte index (exclusive) at which the pad byte still leaves room
  // for the 8-byte length field in the same block.
  localparam int MD5_PAD_LIMIT = 56;
  // Bit position of the little-endian 64-bit length field.
  localparam int MD5_LEN_LSB   = 448;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/md5_msg_sched_if.sv
// md5_msg_sched_if
//   Groups the byte-stream input handshake and the compression-core
//   handshake of the MD5 scheduler.
//   Byte stream : in_valid, in_end, in_byte -> in_ready
//   Core        : core_init, core_start, core_block -> core_done
//   Status      : msg_done, busy, total_len, blk_count
//   slave  modport: the scheduler side.
//   master modport: the producer/core/observer side (testbench, system).
interface md5_msg_sched_if
  import md5_ctrl_pkg::*;
#(
  parameter int LEN_W = 64
);

  logic                      in_valid;
  logic                      in_end;
  logic [7:0]                in_byte;
  logic                      in_ready;

  logic                      core_init;
  logic                      core_start;
  logic [MD5_BLOCK_BITS-1:0] core_block;
  logic                      core_done;

  logic                      msg_done;
  logic                      busy;
  logic [LEN_W-1:0]          total_len;
  logic [15:0]               blk_count;

  modport slave (
    input  in_valid, in_end, in_byte, core_done,
    output in_ready, core_init, core_start, core_block,
           msg_done, busy, total_len, blk_count
  );

  modport master (
    output in_valid, in_end, in_byte, core_done,
    input  in_ready, core_init, core_start, core_block,
           msg_done, busy, total_len, blk_count
  );

endinterface

// File: rtl/md5_block_buf.sv
// md5_block_buf
//   512-bit byte-addressed block register. Byte k lives at bits [8k+7:8k].
//   Ports:
//     clk, reset : clock and synchronous active-low reset (clears block)
//     clr        : start the update from an all-zero block
//     wr_en      : write wr_byte at byte index idx
//     pad_en     : write the pad byte at idx and zero every byte above idx
//     len_en     : place len (little-endian) in the top 8 bytes
//     idx        : byte index for wr_en / pad_en
//     wr_byte    : data byte
//     len        : 64-bit length field value
//     block      : current block contents
//   Operations compose in the order clr -> write/pad -> length, so a pad and
//   a length insert in the same cycle produce a complete final block.
module md5_block_buf
  import md5_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic                      pad_en,
  input  logic                      len_en,
  input  logic [5:0]                idx,
  input  logic [7:0]                wr_byte,
  input  logic [63:0]               len,
  output logic [MD5_BLOCK_BITS-1:0] block
);

  logic [MD5_BLOCK_BITS-1:0] buf_q;
  logic [MD5_BLOCK_BITS-1:0] buf_d;

  always_comb begin
    buf_d = clr ? '0 : buf_q;
    for (int k = 0; k < MD5_BLOCK_BYTES; k++) begin
      if (wr_en && (idx == 6'(k))) begin
        buf_d[8*k +: 8] = wr_byte;
      end
      if (pad_en) begin
        if (idx == 6'(k)) begin
          buf_d[8*k +: 8] = MD5_PAD_BYTE;
        end else if (6'(k) > idx) begin
          buf_d[8*k +: 8] = 8'h00;
        end
      end
    end
    if (len_en) begin
      for (int k = 0; k < 8; k++) begin
        buf_d[MD5_LEN_LSB + 8*k +: 8] = len[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign block = buf_q;

endmodule

// File: rtl/md5_msg_sched.sv
// md5_msg_sched
//   Packs an incoming byte stream into 512-bit MD5 blocks, appends the MD5
//   padding and 64-bit bit-length, and feeds the compression core one block
//   at a time over a start/done handshake.
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-low reset
//     bus   : md5_msg_sched_if.slave
//             in_valid/in_end/in_byte/in_ready : byte or end-of-message input
//             core_init   : pulse, core reloads its initial chaining values
//             core_start  : pulse, core_block valid, compress it
//             core_block  : block under compression, stable until core_done
//             core_done   : pulse from core, block absorbed
//             msg_done    : pulse, final block absorbed, digest valid
//             busy        : not idle
//             total_len   : message length in bits (modulo 2^LEN_W)
//             blk_count   : blocks issued for the current message
module md5_msg_sched
  import md5_ctrl_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic           clk,
  input  logic           reset,
  md5_msg_sched_if.slave bus
);

  state_e           state_q,      state_d;
  logic [5:0]       cnt_q,        cnt_d;
  logic             need_extra_q, need_extra_d;
  logic             last_blk_q,   last_blk_d;
  logic [LEN_W-1:0] total_len_q,  total_len_d;
  logic [15:0]      blk_count_q,  blk_count_d;

  logic             in_ready;
  logic             xfer;
  logic             core_init;
  logic             core_start;
  logic             msg_done;

  logic             buf_clr;
  logic             buf_wr;
  logic             buf_pad;
  logic             buf_len;
  logic [5:0]       buf_idx;
  logic [LEN_W-1:0] len_src;
  logic [63:0]      len64;

  // Ready is forced low while reset is asserted so nothing is accepted in
  // the reset cycle itself.
  assign in_ready = reset && ((state_q == IDLE) || (state_q == FILL));
  assign xfer     = bus.in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    need_extra_d = need_extra_q;
    last_blk_d   = last_blk_q;
    total_len_d  = total_len_q;
    blk_count_d  = blk_count_q;
    buf_clr      = 1'b0;
    buf_wr       = 1'b0;
    buf_pad      = 1'b0;
    buf_len      = 1'b0;
    buf_idx      = cnt_q;
    len_src      = total_len_q;
    core_init    = 1'b0;
    core_start   = 1'b0;
    msg_done     = 1'b0;

    unique case (state_q)
      IDLE, FILL: begin
        if (xfer) begin
          // The first transfer of a message starts from a clean slate: the
          // index, buffer and length are treated as zero for this transfer.
          if (state_q == IDLE) begin
            core_init   = 1'b1;
            buf_clr     = 1'b1;
            buf_idx     = '0;
            len_src     = '0;
            blk_count_d = '0;
          end
          if (!bus.in_end) begin
            buf_wr      = 1'b1;
            cnt_d       = buf_idx + 6'd1;
            total_len_d = len_src + LEN_W'(8);
            if (buf_idx == 6'd63) begin
              last_blk_d = 1'b0;
              state_d    = ISSUE;
            end else begin
              state_d    = FILL;
            end
          end else begin
            buf_pad     = 1'b1;
            total_len_d = len_src;
            if (buf_idx < 6'(MD5_PAD_LIMIT)) begin
              buf_len      = 1'b1;
              need_extra_d = 1'b0;
              last_blk_d   = 1'b1;
            end else begin
              // No room for the length: it goes in an extra block.
              need_extra_d = 1'b1;
              last_blk_d   = 1'b0;
            end
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        core_start  = 1'b1;
        blk_count_d = blk_count_q + 16'd1;
        state_d     = WAIT;
      end

      WAIT: begin
        if (bus.core_done) begin
          if (last_blk_q) begin
            state_d = DONE;
          end else if (need_extra_q) begin
            buf_clr      = 1'b1;
            buf_len      = 1'b1;
            need_extra_d = 1'b0;
            last_blk_d   = 1'b1;
            state_d      = ISSUE;
          end else begin
            buf_clr = 1'b1;
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end

      DONE: begin
        msg_done = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      need_extra_q <= 1'b0;
      last_blk_q   <= 1'b0;
      total_len_q  <= '0;
      blk_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      need_extra_q <= need_extra_d;
      last_blk_q   <= last_blk_d;
      total_len_q  <= total_len_d;
      blk_count_q  <= blk_count_d;
    end
  end

  // Length field is always 64 bits wide; the counter may be narrower or wider.
  generate
    if (LEN_W >= 64) begin : g_len_trunc
      assign len64 = len_src[63:0];
    end else begin : g_len_ext
      assign len64 = {{(64-LEN_W){1'b0}}, len_src};
    end
  endgenerate

  md5_block_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .pad_en  (buf_pad),
    .len_en  (buf_len),
    .idx     (buf_idx),
    .wr_byte (bus.in_byte),
    .len     (len64),
    .block   (bus.core_block)
  );

  assign bus.in_ready   = in_ready;
  assign bus.core_init  = core_init;
  assign bus.core_start = core_start;
  assign bus.msg_done   = msg_done;
  assign bus.busy       = (state_q != IDLE);
  assign bus.total_len  = total_len_q;
  assign bus.blk_count  = blk_count_q;

endmodule

// File: tb/tb_md5_msg_sched.sv
// tb_md5_msg_sched
//   Randomized/directed bench for md5_msg_sched. Expected blocks come from
//   the plain MD5 padding rule (message, 0x80, zeros to 56 mod 64, 64-bit
//   little-endian bit length); handshake timing from a cycle-level model of
//   when a block is outstanding.
module tb_md5_msg_sched;
  import md5_ctrl_pkg::*;

  localparam int LEN_W = 64;
  typedef byte unsigned bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md5_msg_sched_if #(.LEN_W(LEN_W)) bus ();

  md5_msg_sched #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input string name, input bq_t msg, input int lat_max);
    bq_t         pad;
    logic [63:0] bits;
    logic [511:0] exp_blk;
    int nblk, i, blk, cd, cyc;
    bit ended, blocked, first, pending, start_due, done_due, fin, seen_done;
    bit nx_start, nx_done, xfer, cdone;

    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 0; k < 8; k++) pad.push_back(bits[8*k +: 8]);
    nblk = pad.size() / 64;

    i = 0; blk = 0; cd = 0; cyc = 0;
    ended = 0; blocked = 0; first = 1; pending = 0;
    start_due = 0; done_due = 0; fin = 0; seen_done = 0;

    while (!fin) begin
      bus.in_valid = !ended;
      bus.in_end   = (i == msg.size());
      bus.in_byte  = (i < msg.size()) ? msg[i] : 8'($urandom);
      cdone        = pending && (cd == 0);
      // Spurious core_done while filling must have no effect.
      bus.core_done = cdone || (!pending && !blocked && ($urandom_range(0, 3) == 0));
      #1;

      xfer = !ended && !blocked;
      if (!ended) chk({name, " in_ready"}, bus.in_ready, !blocked);
      chk({name, " core_init"}, bus.core_init, xfer && first);
      chk({name, " core_start"}, bus.core_start, start_due);
      chk({name, " msg_done"}, bus.msg_done, done_due);
      if (!first) chk({name, " total_len"}, bus.total_len, 64'(i) * 64'd8);

      nx_start = 0;
      nx_done  = 0;
      if (cdone) begin
        pending = 0;
        if (blk == nblk)   nx_done  = 1;
        else if (ended)    nx_start = 1;
        else               blocked  = 0;
      end else if (pending) begin
        cd--;
      end

      if (start_due) begin
        for (int k = 0; k < 64; k++) exp_blk[8*k +: 8] = pad[64*blk + k];
        chk($sformatf("%s block%0d", name, blk), bus.core_block, exp_blk);
        chk($sformatf("%s blk_count@start%0d", name, blk), bus.blk_count, 16'(blk));
        blk++;
        pending = 1;
        cd = $urandom_range(0, lat_max);
      end

      if (xfer) begin
        first = 0;
        if (i == msg.size()) begin
          ended    = 1;
          blocked  = 1;
          nx_start = 1;
        end else begin
          i++;
          if (i % 64 == 0) begin
            blocked  = 1;
            nx_start = 1;
          end
        end
      end

      if (done_due) begin
        chk({name, " blk_count@done"}, bus.blk_count, 16'(nblk));
        chk({name, " blocks issued"}, 512'(blk), 512'(nblk));
        seen_done = 1;
        fin = 1;
      end

      start_due = nx_start;
      done_due  = nx_done;
      cyc++;
      if (cyc > 4000) fin = 1;
      tick();
    end
    chk({name, " completed"}, seen_done, 1'b1);
    bus.in_valid  = 1'b0;
    bus.in_end    = 1'b0;
    bus.core_done = 1'b0;
    $display("msg %s: len=%0d blocks=%0d cycles=%0d", name, msg.size(), nblk, cyc);
  endtask

  function automatic bq_t rand_msg(input int len);
    bq_t q;
    for (int k = 0; k < len; k++) q.push_back(8'($urandom_range(32, 126)));
    return q;
  endfunction

  initial begin
    bq_t m;
    bus.in_valid  = 1'b0;
    bus.in_end    = 1'b0;
    bus.in_byte   = 8'h00;
    bus.core_done = 1'b0;
    reset         = 1'b0;
    repeat (3) tick();

    chk("rst in_ready", bus.in_ready, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst core_start", bus.core_start, 1'b0);
    chk("rst msg_done", bus.msg_done, 1'b0);
    chk("rst total_len", bus.total_len, 64'd0);
    chk("rst blk_count", bus.blk_count, 16'd0);
    chk("rst core_block", bus.core_block, 512'd0);
    reset = 1'b1;
    tick();
    chk("idle in_ready", bus.in_ready, 1'b1);

    m.delete();
    run_msg("empty", m, 2);

    m.delete();
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    run_msg("abc", m, 3);

    m.delete();
    for (int k = 0; k < 56; k++) m.push_back(8'h41);
    run_msg("A56", m, 2);

    run_msg("r64", rand_msg(64), 3);
    run_msg("r55", rand_msg(55), 1);
    run_msg("r63", rand_msg(63), 2);
    run_msg("r130", rand_msg(130), 3);

    // Reset while a block is outstanding.
    bus.in_valid = 1'b1; bus.in_end = 1'b0; bus.in_byte = 8'h78;
    #1;
    chk("rw core_init", bus.core_init, 1'b1);
    tick();
    bus.in_end = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_end = 1'b0;
    #1;
    chk("rw core_start", bus.core_start, 1'b1);
    tick();
    chk("rw busy wait", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("rw in_ready in reset", bus.in_ready, 1'b0);
    tick();
    reset = 1'b1;
    bus.core_done = 1'b1;
    #1;
    chk("rw busy", bus.busy, 1'b0);
    chk("rw total_len", bus.total_len, 64'd0);
    chk("rw blk_count", bus.blk_count, 16'd0);
    chk("rw core_block", bus.core_block, 512'd0);
    chk("rw core_start", bus.core_start, 1'b0);
    tick();
    bus.core_done = 1'b0;
    #1;
    chk("rw late msg_done", bus.msg_done, 1'b0);
    chk("rw late core_start", bus.core_start, 1'b0);
    chk("rw late busy", bus.busy, 1'b0);
    tick();
    $display("reset during wait exercised");

    run_msg("after_rst", rand_msg(5), 2);

    for (int r = 0; r < 4; r++) begin
      run_msg($sformatf("rnd%0d", r), rand_msg($urandom_range(0, 140)), 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
